jk_bank_sequencer: RTL and testbench
====================================

// Module: jk_bank_sequencer
// PURPOSE
//  Sequences a WIDTH-bit bank of JK flip-flops by issuing a 2-bit J/K code per bit each clock.
//  Accepts multi-cycle commands over a valid/ready handshake: mask clear/set/toggle, count up/down, load.
//  Holds the bank state q internally; exports the per-bit JK codes on jk_bus for observation and tracing.
// PARAMETERS
//  WIDTH  4  bits in the JK flop bank
//  CNT_W  4  width of the repeat-count field; max 2^CNT_W-1 steps per command
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          reset, asynchronous, active-low
//  cmd_valid  in   1          command offered
//  cmd_ready  out  1          sequencer can accept a command (IDLE only)
//  cmd_op     in   3          0 HOLD, 1 CLR, 2 SET, 3 TGL, 4 INC, 5 DEC, 6 LOAD, 7 reserved (=HOLD)
//  cmd_cnt    in   CNT_W      number of clock steps to apply; 0 is treated as 1
//  cmd_data   in   WIDTH      bit mask for CLR/SET/TGL; load value for LOAD; ignored otherwise
//  abort      in   1          terminate the EXEC command early
//  jk_bus     out  2*WIDTH    {J,K} for bit i at [2i+1:2i]; 00 hold, 01 reset, 10 set, 11 toggle
//  q          out  WIDTH      flop bank state
//  busy       out  1          1 in EXEC or DONE
//  done       out  1          one-cycle pulse in DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, q=0, jk_bus=0, done=0, busy=0, cmd_ready=1; captured command cleared.
//  FSM: IDLE -(cmd_valid&cmd_ready)-> EXEC -(last step or abort)-> DONE -> IDLE (DONE lasts exactly one cycle).
//  Accept edge: capture op, data, and rem=(cmd_cnt==0 ? 1 : cmd_cnt); no change to q on this edge.
//  In EXEC, jk_bus is combinational from the captured op, data, and current q; q is updated on every edge by JK semantics.
//  After each step, rem decrements; the edge that applies the step with rem==1 moves to DONE.
//  jk_bus=0 in IDLE and DONE; q holds.
//  Per-bit JK codes:
//    CLR: data[i]?01:00.  SET: data[i]?10:00.  TGL: data[i]?11:00.  LOAD: data[i]?10:01.  HOLD/7: 00.
//    INC: bit i = 11 if q[i-1:0] all 1 (bit0 always 11), else 00.
//    DEC: bit i = 11 if q[i-1:0] all 0 (bit0 always 11), else 00.
//  Arithmetic is modulo 2^WIDTH: INC from all-ones gives 0; DEC from 0 gives all-ones (subject to the optional feature).
//  Latency: accept at edge T; steps at edges T+1..T+n; done=1 during the cycle after edge T+n; cmd_ready=1 again after edge T+n+1.
//  cmd_valid while not ready is ignored; no queuing. Command fields only need to be stable at the accept edge.
//  abort in EXEC: jk_bus is forced to 0 that cycle, so no step is applied. The next edge goes to DONE.
//  abort with the final step: abort wins and the final step is not applied.
//  abort in IDLE or DONE: no effect.
//  rst_n asserted mid-command: immediate abort; q=0; no done pulse.
// CONFIGURATION
//  JK_SATURATE_EN defined:
//    INC with q all-ones and DEC with q==0 drive jk_bus=0, so q sticks at the limit.
//    The remaining steps still consume cycles and done still pulses.
//  JK_SATURATE_EN undefined: INC/DEC wrap modulo 2^WIDTH as above.
// TESTING (WIDTH=4, CNT_W=4)
//  Reset check: rst_n=0 mid-run -> q=0000, cmd_ready=1, busy=0, jk_bus=0 immediately, with no clock edge needed.
//  LOAD data=1010 cnt=0 -> one step: jk_bus=10_01_10_01; q=1010; done pulses 2 cycles after accept.
//  TGL mask=0011 cnt=3 from q=1010 -> q=1001, 1010, 1001; busy for 4 cycles; cmd_ready back on cycle 5.
//  INC cnt=3 from q=1110 -> 1111, 0000, 0001. With JK_SATURATE_EN -> 1111, 1111, 1111.
//  DEC cnt=2 from q=0000 -> 1111, 1110. With JK_SATURATE_EN -> 0000, 0000.
//  Handshake/abort: INC cnt=15 from 0000, abort asserted in step-4 cycle -> q=0011, done next cycle;
//    a second cmd_valid held during busy is ignored and is accepted only in IDLE.

Source files
------------

// File: rtl/jk_bank_sequencer_if.sv
// Command handshake and observation bus for jk_bank_sequencer.
// The master side offers commands; the slave side is the sequencer.
interface jk_bank_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [2:0]         cmd_op;
   logic [CNT_W-1:0]   cmd_cnt;
   logic [WIDTH-1:0]   cmd_data;
   logic               abort;
   logic [2*WIDTH-1:0] jk_bus;
   logic [WIDTH-1:0]   q;
   logic               busy;
   logic               done;

   modport master (
      output cmd_valid, cmd_op, cmd_cnt, cmd_data, abort,
      input  cmd_ready, jk_bus, q, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_cnt, cmd_data, abort,
      output cmd_ready, jk_bus, q, busy, done
   );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Multi-cycle command sequencer driving a WIDTH-bit JK flop bank, one J/K code per bit per clock.
// Optional JK_SATURATE_EN: INC/DEC stick at all-ones/zero instead of wrapping.

// One bank bit: decodes the captured op into a JK code and applies JK semantics.
module jk_bit_cell (
   input  logic [2:0] op,
   input  logic       en,
   input  logic       d,
   input  logic       lo_ones,
   input  logic       lo_zeros,
   input  logic       qb,
   output logic [1:0] jk,
   output logic       qn
);
   localparam logic [2:0] OP_CLR  = 3'd1;
   localparam logic [2:0] OP_SET  = 3'd2;
   localparam logic [2:0] OP_TGL  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;
   localparam logic [2:0] OP_DEC  = 3'd5;
   localparam logic [2:0] OP_LOAD = 3'd6;

   always_comb begin
      jk = 2'b00;
      if (en) begin
         case (op)
            OP_CLR:  jk = d ? 2'b01 : 2'b00;
            OP_SET:  jk = d ? 2'b10 : 2'b00;
            OP_TGL:  jk = d ? 2'b11 : 2'b00;
            // ripple-carry / borrow expressed as a toggle when all lower bits allow it
            OP_INC:  jk = lo_ones  ? 2'b11 : 2'b00;
            OP_DEC:  jk = lo_zeros ? 2'b11 : 2'b00;
            OP_LOAD: jk = d ? 2'b10 : 2'b01;
            default: jk = 2'b00;
         endcase
      end
   end

   always_comb begin
      qn = qb;
      case (jk)
         2'b01:   qn = 1'b0;
         2'b10:   qn = 1'b1;
         2'b11:   qn = ~qb;
         default: qn = qb;
      endcase
   end
endmodule

module jk_bank_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   jk_bank_sequencer_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t                  state, state_nxt;
   logic [2:0]              op_r;
   logic [WIDTH-1:0]        data_r;
   logic [WIDTH-1:0]        q_r, q_nxt;
   logic [CNT_W-1:0]        rem_r;
   logic                    accept, step_en, sat;
   logic [WIDTH-1:0]        lo_ones, lo_zeros;
   logic [WIDTH-1:0][1:0]   jk;

   assign accept = bus.cmd_valid && (state == S_IDLE);

`ifdef JK_SATURATE_EN
   localparam logic [2:0] OP_INC = 3'd4;
   localparam logic [2:0] OP_DEC = 3'd5;
   // at the limit the whole bank holds; the step still consumes its cycle
   assign sat = ((op_r == OP_INC) && (&q_r)) || ((op_r == OP_DEC) && ~(|q_r));
`else
   assign sat = 1'b0;
`endif

   // abort suppresses the step in the cycle it is seen
   assign step_en = (state == S_EXEC) && !bus.abort && !sat;

   assign lo_ones[0]  = 1'b1;
   assign lo_zeros[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_chain
      assign lo_ones[i]  = lo_ones[i-1]  & q_r[i-1];
      assign lo_zeros[i] = lo_zeros[i-1] & ~q_r[i-1];
   end

   jk_bit_cell u_cell [WIDTH-1:0] (
      .op       (op_r),
      .en       (step_en),
      .d        (data_r),
      .lo_ones  (lo_ones),
      .lo_zeros (lo_zeros),
      .qb       (q_r),
      .jk       (jk),
      .qn       (q_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_EXEC;
         S_EXEC:  if (bus.abort || rem_r == CNT_W'(1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= 3'd0;
         data_r <= '0;
         rem_r  <= '0;
         q_r    <= '0;
      end else begin
         if (accept) begin
            op_r   <= bus.cmd_op;
            data_r <= bus.cmd_data;
            rem_r  <= (bus.cmd_cnt == '0) ? CNT_W'(1) : bus.cmd_cnt;
         end else if (state == S_EXEC) begin
            rem_r  <= rem_r - CNT_W'(1);
         end
         // jk is zero outside EXEC, so this holds q there
         q_r <= q_nxt;
      end
   end

   assign bus.cmd_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.q         = q_r;
   assign bus.jk_bus    = jk;
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Randomized + directed bench for jk_bank_sequencer against an arithmetic reference model.
module tb_jk_bank_sequencer;
   localparam int WIDTH = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [WIDTH-1:0] mq = '0;

   jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic is_sat(input logic [2:0] op, input logic [3:0] qv);
`ifdef JK_SATURATE_EN
      return (op == 3'd4 && qv == 4'hf) || (op == 3'd5 && qv == 4'h0);
`else
      return 1'b0;
`endif
   endfunction

   // next bank value from plain arithmetic/boolean rules
   function automatic logic [3:0] step_q(input logic [2:0] op, input logic [3:0] d, input logic [3:0] qv);
      if (is_sat(op, qv)) return qv;
      case (op)
         3'd1: return qv & ~d;
         3'd2: return qv | d;
         3'd3: return qv ^ d;
         3'd4: return qv + 4'd1;
         3'd5: return qv - 4'd1;
         3'd6: return d;
         default: return qv;
      endcase
   endfunction

   // code per bit: INC/DEC toggle exactly the bits that change under +1/-1
   function automatic logic [7:0] exp_jk(input logic [2:0] op, input logic [3:0] d, input logic [3:0] qv);
      logic [7:0] r;
      logic [3:0] t;
      r = '0;
      t = '0;
      if (op == 3'd4) t = qv ^ (qv + 4'd1);
      if (op == 3'd5) t = qv ^ (qv - 4'd1);
      if (is_sat(op, qv)) return 8'h00;
      for (int i = 0; i < 4; i++) begin
         case (op)
            3'd1: r[2*i +: 2] = d[i] ? 2'b01 : 2'b00;
            3'd2: r[2*i +: 2] = d[i] ? 2'b10 : 2'b00;
            3'd3: r[2*i +: 2] = d[i] ? 2'b11 : 2'b00;
            3'd4, 3'd5: r[2*i +: 2] = t[i] ? 2'b11 : 2'b00;
            3'd6: r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
            default: r[2*i +: 2] = 2'b00;
         endcase
      end
      return r;
   endfunction

   // Called at a negedge in IDLE; returns at a negedge in IDLE after the done cycle.
   // ab = step number (1-based) at which abort is raised, 0 for none.
   // pend = hold a second LOAD 0101 command valid throughout the busy period.
   task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [3:0] d,
                          input int ab, input bit pend);
      int n;
      n = (cnt == 4'd0) ? 1 : int'(cnt);
      chk("ready_idle", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_cnt   = cnt;
      bus.cmd_data  = d;
      @(negedge clk);
      if (pend) begin
         bus.cmd_op   = 3'd6;
         bus.cmd_cnt  = 4'd1;
         bus.cmd_data = 4'b0101;
      end else begin
         bus.cmd_valid = 1'b0;
         bus.cmd_op    = 3'($urandom);
         bus.cmd_cnt   = 4'($urandom);
         bus.cmd_data  = 4'($urandom);
      end
      chk("q_accept", bus.q, mq);
      for (int s = 1; s <= n; s++) begin
         if (s == ab) bus.abort = 1'b1;
         #1;
         chk("busy", bus.busy, 1'b1);
         chk("ready_exec", bus.cmd_ready, 1'b0);
         chk("done_exec", bus.done, 1'b0);
         chk("jk", bus.jk_bus, (s == ab) ? 8'h00 : exp_jk(op, d, mq));
         @(negedge clk);
         bus.abort = 1'b0;
         if (s == ab) break;
         mq = step_q(op, d, mq);
         chk("q_step", bus.q, mq);
      end
      chk("done", bus.done, 1'b1);
      chk("busy_done", bus.busy, 1'b1);
      chk("jk_done", bus.jk_bus, 8'h00);
      chk("q_done", bus.q, mq);
      @(negedge clk);
      chk("done_clr", bus.done, 1'b0);
      chk("ready_back", bus.cmd_ready, 1'b1);
      chk("q_idle", bus.q, mq);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_cnt   = 4'd0;
      bus.cmd_data  = 4'd0;
      bus.abort     = 1'b0;
      #12;
      chk("rst_q", bus.q, 4'h0);
      chk("rst_ready", bus.cmd_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_jk", bus.jk_bus, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // directed examples
      run_cmd(3'd6, 4'd0, 4'b1010, 0, 1'b0);
      chk("load_q", bus.q, 4'b1010);
      run_cmd(3'd3, 4'd3, 4'b0011, 0, 1'b0);
      chk("tgl_q", bus.q, 4'b1001);
      run_cmd(3'd6, 4'd1, 4'b1110, 0, 1'b0);
      run_cmd(3'd4, 4'd3, 4'd0, 0, 1'b0);
`ifdef JK_SATURATE_EN
      chk("inc_q", bus.q, 4'b1111);
`else
      chk("inc_q", bus.q, 4'b0001);
`endif
      run_cmd(3'd6, 4'd1, 4'b0000, 0, 1'b0);
      run_cmd(3'd5, 4'd2, 4'd0, 0, 1'b0);
`ifdef JK_SATURATE_EN
      chk("dec_q", bus.q, 4'b0000);
`else
      chk("dec_q", bus.q, 4'b1110);
`endif
      run_cmd(3'd6, 4'd1, 4'b0000, 0, 1'b0);
      run_cmd(3'd4, 4'd15, 4'd0, 4, 1'b1);
      chk("abort_q", bus.q, 4'b0011);
      run_cmd(3'd6, 4'd1, 4'b0101, 0, 1'b0);
      chk("pend_q", bus.q, 4'b0101);

      // abort outside EXEC does nothing
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_idle_q", bus.q, mq);
      chk("abort_idle_ready", bus.cmd_ready, 1'b1);

      // final step aborted: not applied
      run_cmd(3'd3, 4'd2, 4'b1111, 2, 1'b0);

      // randomized commands
      for (int k = 0; k < 40; k++) begin
         logic [2:0] op;
         logic [3:0] cnt, d;
         int         ab;
         op  = 3'($urandom);
         cnt = 4'($urandom_range(0, 6));
         d   = 4'($urandom);
         ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, (cnt == 0) ? 1 : cnt)) : 0;
         run_cmd(op, cnt, d, ab, 1'b0);
      end

      // asynchronous reset mid-command
      run_cmd(3'd6, 4'd1, 4'b0110, 0, 1'b0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd4;
      bus.cmd_cnt   = 4'd10;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      mq = '0;
      chk("mid_rst_q", bus.q, 4'h0);
      chk("mid_rst_ready", bus.cmd_ready, 1'b1);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_jk", bus.jk_bus, 8'h00);
      chk("mid_rst_done", bus.done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_done", bus.done, 1'b0);
      chk("post_rst_q", bus.q, 4'h0);
      run_cmd(3'd2, 4'd1, 4'b1001, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
